// File: rtl/sp_compare_issue.sv
// Issue/retire stage in front of the single-precision compare unit: holds one op,
// drives the comparator handshake, and returns a tagged integer result with a timeout guard.
module sp_compare_issue #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_func3,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  output logic        cmp_start,
  output logic [31:0] cmp_operand_a,
  output logic [31:0] cmp_operand_b,
  output logic [2:0]  cmp_func3,
  input  logic        cmp_flag_cmp,
  input  logic        cmp_flag_invalid,
  input  logic        cmp_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_nv,
  output logic        out_illegal,
  output logic        out_timeout,
  input  logic        fflags_clr,
  output logic        fflags_nv,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_count;
  logic [31:0]     r_opA;
  logic [31:0]     r_opB;
  logic [2:0]      r_func3;
  logic [4:0]      r_rd;
  logic            r_resBit;
  logic [4:0]      r_outRd;
  logic            r_outNv;
  logic            r_outIllegal;
  logic            r_outTimeout;
  logic            r_fflagsNv;

  logic            w_accept;
  logic            w_legal;
  logic            w_inIssue;
  logic            w_inResp;
  logic            w_doneHit;
  logic            w_timeoutHit;
  logic            w_nvSet;

  assign w_inIssue    = (r_state == S_ISSUE);
  assign w_inResp     = (r_state == S_RESP);
  assign w_legal      = (in_func3 == 3'b010) || (in_func3 == 3'b001) || (in_func3 == 3'b000);
  assign in_ready     = !rst && ((r_state == S_IDLE) || (w_inResp && out_ready));
  assign w_accept     = in_valid && in_ready;
  assign w_doneHit    = w_inIssue && cmp_done;
  assign w_timeoutHit = w_inIssue && !cmp_done && (r_count == TO_W'(TIMEOUT - 1));
  assign w_nvSet      = w_inResp && out_ready && r_outNv;

  assign cmp_start     = !rst && w_inIssue;
  assign cmp_operand_a = r_opA;
  assign cmp_operand_b = r_opB;
  assign cmp_func3     = r_func3;
  assign out_valid     = w_inResp;
  assign out_result    = {31'b0, r_resBit};
  assign out_rd        = r_outRd;
  assign out_nv        = r_outNv;
  assign out_illegal   = r_outIllegal;
  assign out_timeout   = r_outTimeout;
  assign fflags_nv     = r_fflagsNv;
  assign busy          = (r_state != S_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_legal ? S_ISSUE : S_RESP;
      end
      S_ISSUE: begin
        if (w_doneHit || w_timeoutHit) w_next = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          if (w_accept) w_next = w_legal ? S_ISSUE : S_RESP;
          else          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Accept and ISSUE-side capture never coincide, so the result registers have a single writer per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_opA        <= '0;
      r_opB        <= '0;
      r_func3      <= '0;
      r_rd         <= '0;
      r_resBit     <= 1'b0;
      r_outRd      <= '0;
      r_outNv      <= 1'b0;
      r_outIllegal <= 1'b0;
      r_outTimeout <= 1'b0;
      r_fflagsNv   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_opA   <= in_a;
        r_opB   <= in_b;
        r_func3 <= in_func3;
        r_rd    <= in_rd;
      end

      if (w_accept && !w_legal) begin
        r_resBit     <= 1'b0;
        r_outNv      <= 1'b0;
        r_outIllegal <= 1'b1;
        r_outTimeout <= 1'b0;
        r_outRd      <= in_rd;
      end else if (w_doneHit) begin
        r_resBit     <= cmp_flag_cmp;
        r_outNv      <= cmp_flag_invalid;
        r_outIllegal <= 1'b0;
        r_outTimeout <= 1'b0;
        r_outRd      <= r_rd;
      end else if (w_timeoutHit) begin
        r_resBit     <= 1'b0;
        r_outNv      <= 1'b0;
        r_outIllegal <= 1'b0;
        r_outTimeout <= 1'b1;
        r_outRd      <= r_rd;
      end

      if (w_accept && w_legal) r_count <= '0;
      else if (w_inIssue && !cmp_done) r_count <= r_count + 1'b1;

      if (w_nvSet)         r_fflagsNv <= 1'b1;
      else if (fflags_clr) r_fflagsNv <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sp_compare_issue.sv
// Directed bench for sp_compare_issue with a behavioural single-precision comparator
// attached to the start/done port; expected results are hand-computed constants.
module tb_sp_compare_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_func3;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        cmp_start;
  logic [31:0] cmp_operand_a;
  logic [31:0] cmp_operand_b;
  logic [2:0]  cmp_func3;
  logic        cmp_flag_cmp;
  logic        cmp_flag_invalid;
  logic        cmp_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_nv;
  logic        out_illegal;
  logic        out_timeout;
  logic        fflags_clr;
  logic        fflags_nv;
  logic        busy;
  logic        doneEn;

  int nChecks = 0;
  int nPass   = 0;

  sp_compare_issue #(.TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_func3(in_func3),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .cmp_start(cmp_start), .cmp_operand_a(cmp_operand_a), .cmp_operand_b(cmp_operand_b),
    .cmp_func3(cmp_func3), .cmp_flag_cmp(cmp_flag_cmp), .cmp_flag_invalid(cmp_flag_invalid),
    .cmp_done(cmp_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_nv(out_nv), .out_illegal(out_illegal), .out_timeout(out_timeout),
    .fflags_clr(fflags_clr), .fflags_nv(fflags_nv), .busy(busy)
  );

  always #5 clk = ~clk;

  // Comparator stand-in: answers in the same cycle it is started unless doneEn is dropped.
  function automatic logic [1:0] fpCmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    logic nanA, nanB, sA, sB, bothZero, eq, lt, res, nv;
    nanA     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nanB     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    sA       = nanA && !a[22];
    sB       = nanB && !b[22];
    bothZero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    eq       = bothZero || (a == b);
    if (bothZero)         lt = 1'b0;
    else if (a[31] != b[31]) lt = a[31];
    else if (!a[31])      lt = a[30:0] < b[30:0];
    else                  lt = a[30:0] > b[30:0];
    res = 1'b0;
    nv  = 1'b0;
    case (f)
      3'b010: begin nv = sA || sB;     res = !(nanA || nanB) && eq;        end
      3'b001: begin nv = nanA || nanB; res = !(nanA || nanB) && lt;        end
      3'b000: begin nv = nanA || nanB; res = !(nanA || nanB) && (lt || eq); end
      default: begin nv = 1'b0; res = 1'b0; end
    endcase
    return {res, nv};
  endfunction

  always_comb begin
    {cmp_flag_cmp, cmp_flag_invalid} = fpCmp(cmp_operand_a, cmp_operand_b, cmp_func3);
    cmp_done = cmp_start && doneEn;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1'b1;
    in_func3 = f;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_func3 = 3'b000; in_a = '0; in_b = '0; in_rd = '0;
    out_ready = 1'b1; fflags_clr = 1'b0; doneEn = 1'b1;
    tick(); tick();
    nChecks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b want 0", busy); else nPass++;
    nChecks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %0b want 0", in_ready); else nPass++;
    nChecks++; if (cmp_start !== 1'b0) $display("[TB] FAIL reset_cmp_start got %0b want 0", cmp_start); else nPass++;
    nChecks++; if ({out_result, out_rd, cmp_operand_a, fflags_nv} !== 70'd0)
      $display("[TB] FAIL reset_regs got res=%h rd=%0d opa=%h nv=%0b want all 0", out_result, out_rd, cmp_operand_a, fflags_nv);
    else nPass++;
    rst = 1'b0;
    tick();
    nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL idle_in_ready got %0b want 1", in_ready); else nPass++;
  endtask

  task automatic test_flt_latency();
    sendOp(3'b001, 32'h3F800000, 32'h40000000, 5'd3);
    nChecks++; if (cmp_start !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL flt_issue_cycle got start=%0b valid=%0b want 1/0", cmp_start, out_valid);
    else nPass++;
    tick();
    nChecks++; if (out_valid !== 1'b1) $display("[TB] FAIL flt_valid_at_2 got %0b want 1", out_valid); else nPass++;
    nChecks++; if (out_result !== 32'd1 || out_nv !== 1'b0 || out_rd !== 5'd3)
      $display("[TB] FAIL flt_result got res=%h nv=%0b rd=%0d want 1/0/3", out_result, out_nv, out_rd);
    else nPass++;
    tick();
    nChecks++; if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("[TB] FAIL flt_retire got busy=%0b valid=%0b want 0/0", busy, out_valid);
    else nPass++;
  endtask

  task automatic test_snan_fflags();
    sendOp(3'b010, 32'h7F800001, 32'h3F800000, 5'd8);
    tick();
    nChecks++; if (out_valid !== 1'b1 || out_result !== 32'd0 || out_nv !== 1'b1)
      $display("[TB] FAIL feq_snan got valid=%0b res=%h nv=%0b want 1/0/1", out_valid, out_result, out_nv);
    else nPass++;
    nChecks++; if (fflags_nv !== 1'b0) $display("[TB] FAIL fflags_before_hs got %0b want 0", fflags_nv); else nPass++;
    tick();
    nChecks++; if (fflags_nv !== 1'b1) $display("[TB] FAIL fflags_after_hs got %0b want 1", fflags_nv); else nPass++;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    nChecks++; if (fflags_nv !== 1'b0) $display("[TB] FAIL fflags_clr got %0b want 0", fflags_nv); else nPass++;
  endtask

  task automatic test_zero_nan();
    sendOp(3'b000, 32'h00000000, 32'h80000000, 5'd10);
    tick();
    nChecks++; if (out_result !== 32'd1 || out_nv !== 1'b0)
      $display("[TB] FAIL fle_zeros got res=%h nv=%0b want 1/0", out_result, out_nv);
    else nPass++;
    tick();
    sendOp(3'b001, 32'h00000000, 32'h80000000, 5'd11);
    tick();
    nChecks++; if (out_result !== 32'd0 || out_nv !== 1'b0)
      $display("[TB] FAIL flt_zeros got res=%h nv=%0b want 0/0", out_result, out_nv);
    else nPass++;
    tick();
    sendOp(3'b001, 32'h7FC00000, 32'h3F800000, 5'd12);
    tick();
    nChecks++; if (out_result !== 32'd0 || out_nv !== 1'b1 || out_rd !== 5'd12)
      $display("[TB] FAIL flt_qnan got res=%h nv=%0b rd=%0d want 0/1/12", out_result, out_nv, out_rd);
    else nPass++;
    tick();
    nChecks++; if (fflags_nv !== 1'b1) $display("[TB] FAIL fflags_qnan got %0b want 1", fflags_nv); else nPass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    sendOp(3'b001, 32'h3F800000, 32'h40000000, 5'd7);
    tick();
    for (int i = 0; i < 5; i++) begin
      nChecks++; if (out_valid !== 1'b1 || out_result !== 32'd1 || out_rd !== 5'd7 || in_ready !== 1'b0)
        $display("[TB] FAIL bp_hold_%0d got valid=%0b res=%h rd=%0d in_ready=%0b want 1/1/7/0",
                 i, out_valid, out_result, out_rd, in_ready);
      else nPass++;
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1; in_func3 = 3'b000; in_a = 32'h40000000; in_b = 32'h3F800000; in_rd = 5'd9;
    #1;
    nChecks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready got %0b want 1", in_ready); else nPass++;
    tick();
    in_valid = 1'b0;
    nChecks++; if (out_valid !== 1'b0 || cmp_start !== 1'b1 || cmp_operand_a !== 32'h40000000)
      $display("[TB] FAIL b2b_issue got valid=%0b start=%0b opa=%h want 0/1/40000000", out_valid, cmp_start, cmp_operand_a);
    else nPass++;
    tick();
    nChecks++; if (out_valid !== 1'b1 || out_result !== 32'd0 || out_rd !== 5'd9)
      $display("[TB] FAIL b2b_result got valid=%0b res=%h rd=%0d want 1/0/9", out_valid, out_result, out_rd);
    else nPass++;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    doneEn = 1'b0;
    sendOp(3'b001, 32'h3F800000, 32'h40000000, 5'd4);
    n = 0;
    while (cmp_start === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    nChecks++; if (n !== 15) $display("[TB] FAIL timeout_cycles got %0d want 15", n); else nPass++;
    nChecks++; if (out_valid !== 1'b1 || out_timeout !== 1'b1 || out_result !== 32'd0 || out_nv !== 1'b0 || out_rd !== 5'd4)
      $display("[TB] FAIL timeout_result got valid=%0b to=%0b res=%h nv=%0b rd=%0d want 1/1/0/0/4",
               out_valid, out_timeout, out_result, out_nv, out_rd);
    else nPass++;
    doneEn = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    sendOp(3'b011, 32'h3F800000, 32'h40000000, 5'd5);
    nChecks++; if (cmp_start !== 1'b0 || out_valid !== 1'b1)
      $display("[TB] FAIL illegal_path got start=%0b valid=%0b want 0/1", cmp_start, out_valid);
    else nPass++;
    nChecks++; if (out_illegal !== 1'b1 || out_timeout !== 1'b0 || out_result !== 32'd0 || out_nv !== 1'b0 || out_rd !== 5'd5)
      $display("[TB] FAIL illegal_result got ill=%0b to=%0b res=%h nv=%0b rd=%0d want 1/0/0/0/5",
               out_illegal, out_timeout, out_result, out_nv, out_rd);
    else nPass++;
    tick();
    sendOp(3'b010, 32'h3F800000, 32'h3F800000, 5'd13);
    tick();
    nChecks++; if (out_illegal !== 1'b0 || out_result !== 32'd1)
      $display("[TB] FAIL illegal_clears got ill=%0b res=%h want 0/1", out_illegal, out_result);
    else nPass++;
    tick();
  endtask

  task automatic test_reset_mid_op();
    doneEn = 1'b0;
    sendOp(3'b010, 32'h7F800001, 32'h3F800000, 5'd2);
    nChecks++; if (busy !== 1'b1 || fflags_nv !== 1'b1)
      $display("[TB] FAIL pre_reset got busy=%0b fflags=%0b want 1/1", busy, fflags_nv);
    else nPass++;
    rst = 1'b1;
    tick();
    nChecks++; if (out_valid !== 1'b0 || busy !== 1'b0 || fflags_nv !== 1'b0)
      $display("[TB] FAIL mid_reset got valid=%0b busy=%0b fflags=%0b want 0/0/0", out_valid, busy, fflags_nv);
    else nPass++;
    rst    = 1'b0;
    doneEn = 1'b1;
    sendOp(3'b001, 32'h3F800000, 32'h40000000, 5'd6);
    tick();
    nChecks++; if (out_valid !== 1'b1 || out_result !== 32'd1 || out_rd !== 5'd6 || out_nv !== 1'b0)
      $display("[TB] FAIL post_reset_op got valid=%0b res=%h rd=%0d nv=%0b want 1/1/6/0", out_valid, out_result, out_rd, out_nv);
    else nPass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_flt_latency();
    test_snan_fflags();
    test_zero_nan();
    test_backpressure();
    test_timeout();
    test_illegal();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
